// File: rtl/gf2m8_vec_mul_gated_if.sv
// Bus bundle for the gated GF(2^8) scalar-by-vector multiplier bank.
// With GF2M8_XOR_PAIR_EN defined, the bundle also carries the second operand pair w/v.
interface gf2m8_vec_mul_gated_if #(
  parameter int unsigned N = 6
);
  logic           ena;
  logic [7:0]     x;
  logic [8*N-1:0] y;
  logic [8*N-1:0] z;
  logic           z_valid;
`ifdef GF2M8_XOR_PAIR_EN
  logic [7:0]     w;
  logic [8*N-1:0] v;

  modport master (output ena, x, y, w, v, input z, z_valid);
  modport slave  (input ena, x, y, w, v, output z, z_valid);
`else
  modport master (output ena, x, y, input z, z_valid);
  modport slave  (input ena, x, y, output z, z_valid);
`endif
endinterface

// File: rtl/gf2m8_vec_mul_gated.sv
// Registered scalar-by-vector GF(2^8) multiplier bank (poly 0x11D) with clock-gated result regs.
// Define GF2M8_XOR_PAIR_EN to register (x*y_i) ^ (w*v_i) per lane instead of x*y_i.
module gf2m8_vec_mul_gated #(
  parameter int unsigned N = 6
) (
  input logic                   clk,
  input logic                   rstn,
  gf2m8_vec_mul_gated_if.slave  bus
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      // Multiply p by the field generator, folding x^8 back in as 0x1D.
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  logic           en_latch;
  logic           gclk;
  logic [8*N-1:0] prod;
  logic [8*N-1:0] z_d, z_q;
  logic           z_valid_d, z_valid_q;

  // Transparent-low latch keeps the gate enable stable while clk is high.
  always_latch begin
    if (!clk) en_latch <= bus.ena | ~rstn;
  end

  assign gclk = clk & en_latch;

  for (genvar i = 0; i < int'(N); i++) begin : g_lane
`ifdef GF2M8_XOR_PAIR_EN
    assign prod[8*i +: 8] = gf_mul(bus.x, bus.y[8*i +: 8]) ^ gf_mul(bus.w, bus.v[8*i +: 8]);
`else
    assign prod[8*i +: 8] = gf_mul(bus.x, bus.y[8*i +: 8]);
`endif
  end

  always_comb begin
    z_d       = z_q;
    z_valid_d = 1'b0;
    if (bus.ena) begin
      z_d       = prod;
      z_valid_d = 1'b1;
    end
  end

  always_ff @(posedge gclk) begin
    if (!rstn) z_q <= '0;
    else       z_q <= z_d;
  end

  // Valid is on the free-running clock so it can drop while the gate is closed.
  always_ff @(posedge clk) begin
    if (!rstn) z_valid_q <= 1'b0;
    else       z_valid_q <= z_valid_d;
  end

  assign bus.z       = z_q;
  assign bus.z_valid = z_valid_q;

endmodule

// File: tb/tb_gf2m8_vec_mul_gated.sv
// Self-checking bench for gf2m8_vec_mul_gated: directed test-plan steps, then random traffic
// checked against a carry-less-multiply-then-divide reference model.
module tb_gf2m8_vec_mul_gated;
  localparam int unsigned N = 6;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  logic [8*N-1:0] exp_z;
  logic           exp_v;

  gf2m8_vec_mul_gated_if #(.N(N)) bus ();

  gf2m8_vec_mul_gated #(.N(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full 15-bit polynomial product, then long division by 0x11D.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0000;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int k = 15; k >= 8; k--)
      if (prod[k]) prod = prod ^ (16'h011D << (k - 8));
    return prod[7:0];
  endfunction

  function automatic logic [8*N-1:0] ref_vec();
    logic [8*N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      r[8*i +: 8] = ref_mul(bus.x, bus.y[8*i +: 8]);
`ifdef GF2M8_XOR_PAIR_EN
      r[8*i +: 8] = r[8*i +: 8] ^ ref_mul(bus.w, bus.v[8*i +: 8]);
`endif
    end
    return r;
  endfunction

  // Advance one clock, updating the model from the inputs applied before the edge.
  task automatic step();
    logic [8*N-1:0] nz;
    logic           nv;
    nz = exp_z;
    nv = 1'b0;
    if (!rstn) begin
      nz = '0;
    end else if (bus.ena) begin
      nz = ref_vec();
      nv = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_z = nz;
    exp_v = nv;
  endtask

  task automatic chk(input string tag, input logic [8*N-1:0] obs, input logic [8*N-1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".z"}, bus.z, exp_z);
    chk({tag, ".v"}, {{(8*N-1){1'b0}}, bus.z_valid}, {{(8*N-1){1'b0}}, exp_v});
  endtask

  task automatic chk_v(input string tag, input logic v);
    chk(tag, {{(8*N-1){1'b0}}, bus.z_valid}, {{(8*N-1){1'b0}}, v});
  endtask

  function automatic logic [8*N-1:0] rand_vec();
    logic [8*N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_z  = '0;
    exp_v  = 1'b0;
    rstn   = 1'b0;
    bus.ena = 1'b1;
    bus.x   = 8'h55;
    bus.y   = {N{8'hFF}};
`ifdef GF2M8_XOR_PAIR_EN
    bus.w   = 8'h00;
    bus.v   = '0;
`endif

    // Reset overrides ena
    step();
    step();
    chk("reset.z", bus.z, '0);
    chk_v("reset.v", 1'b0);
    rstn    = 1'b1;
    bus.ena = 1'b0;
    step();
    chk("idle.z", bus.z, '0);
    chk_v("idle.v", 1'b0);

    // Basic products; lane 0 is the low byte
    bus.ena = 1'b1;
    bus.x   = 8'h02;
    bus.y   = {8'h01, 8'h00, 8'hFF, 8'h03, 8'h80, 8'h02};
    step();
    chk("basic.z", bus.z, {8'h02, 8'h00, 8'hE3, 8'h06, 8'h1D, 8'h04});
    chk_v("basic.v", 1'b1);
    chk_model("basic.model");

    // Reduction
    bus.x = 8'h80;
    bus.y = {N{8'h80}};
    step();
    chk("red80.z", bus.z, {N{8'h13}});
    bus.x = 8'h03;
    bus.y = {N{8'h03}};
    step();
    chk("red03.z", bus.z, {N{8'h05}});

    // Hold while gated
    bus.x = 8'h80;
    bus.y = {N{8'h80}};
    step();
    chk("hold.load", bus.z, {N{8'h13}});
    bus.ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.x = 8'($urandom_range(0, 255));
      bus.y = rand_vec();
      step();
      chk("hold.z", bus.z, {N{8'h13}});
      chk_v("hold.v", 1'b0);
    end

    // Back-to-back, then reset coincident with the third operand
    bus.ena = 1'b1;
    bus.y   = {N{8'h01}};
    bus.x   = 8'h01;
    step();
    chk("b2b1.z", bus.z, {N{8'h01}});
    bus.x = 8'h02;
    step();
    chk("b2b2.z", bus.z, {N{8'h02}});
    chk_v("b2b2.v", 1'b1);
    bus.x = 8'h04;
    rstn  = 1'b0;
    step();
    chk("midrst.z", bus.z, '0);
    chk_v("midrst.v", 1'b0);
    rstn = 1'b1;
    step();
    chk("postrst.z", bus.z, {N{8'h04}});

    // Identity and zero boundaries
    bus.x = 8'h01;
    bus.y = rand_vec();
    step();
    chk("x1.z", bus.z, exp_z);
    chk_model("x1.model");
    bus.x = 8'h00;
    step();
    chk("x0.z", bus.z, '0);

`ifdef GF2M8_XOR_PAIR_EN
    bus.x = 8'h02;
    bus.y = {N{8'h02}};
    bus.w = 8'h03;
    bus.v = {N{8'h03}};
    step();
    chk("xor.z", bus.z, {N{8'h01}});
    bus.x = 8'h5A;
    bus.w = 8'h5A;
    bus.y = rand_vec();
    bus.v = bus.y;
    step();
    chk("xor0.z", bus.z, '0);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      rstn    = ($urandom_range(0, 19) != 0);
      bus.ena = ($urandom_range(0, 3) != 0);
      bus.x   = 8'($urandom_range(0, 255));
      bus.y   = rand_vec();
`ifdef GF2M8_XOR_PAIR_EN
      bus.w   = 8'($urandom_range(0, 255));
      bus.v   = rand_vec();
`endif
      step();
      chk_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
